pipe_id_stage: RTL
==================

PIPE_ID_STAGE -- requirements
Module: pipe_id_stage

Interface
REQ-001 SHALL provide ports (clock and reset first):
- clock  in  1  pipeline clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- dpc4  in  32  PC+4 of decoded instruction, from IF/ID register
- inst  in  32  instruction from IF/ID register
- ern, mrn, wrn  in  5 each  destination register in EX, MEM, WB
- ewreg, em2reg, mwreg, mm2reg, wwreg  in  1 each  write-enable and load flags in EX/MEM/WB
- ealu, malu, mmo, wdi  in  32 each  EX ALU result, MEM ALU result, MEM load data, WB write data
- wpcir  out  1  0 = stall PC and IF/ID register
- pcsource  out  2  next-PC select: 00 pc4, 01 branch, 10 jr, 11 jump
- bpc, jpc  out  32  branch target, jump target
- da, db, dimm  out  32 each  operand A, operand B, extended immediate
- drn  out  5  destination register
- wreg, m2reg, wmem, jal, aluimm, shift  out  1 each  control to ID/EX register
- aluc  out  4  ALU operation code

Function
REQ-002 SHALL decode add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal; any other encoding SHALL decode as NOP (all write/branch controls 0).
REQ-003 SHALL use aluc: add/addi/lw/sw x000, sub/beq/bne x100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111.
REQ-004 SHALL set drn = rd (R-type), rt (I-type), 31 (jal).
REQ-005 SHALL set dimm = zero-extended imm16 for andi/ori/xori, sign-extended otherwise; bpc = dpc4 + (sext(imm16) << 2) mod 2^32; jpc = {dpc4[31:28], inst[25:0], 2'b00}.
REQ-006 SHALL forward da/db with priority EX over MEM over WB over register file: EX if ewreg & !em2reg & ern==src; MEM ALU if mwreg & !mm2reg & mrn==src; MEM load if mwreg & mm2reg & mrn==src; source index 0 SHALL never forward and SHALL read 0.
REQ-007 SHALL drive wpcir=0 when ewreg & em2reg & ern!=0 & ern equals an actually-used rs or rt (rt used only by R-type, sw, beq, bne); else wpcir=1.
REQ-008 While wpcir=0, SHALL force wreg=0, wmem=0, jal=0, pcsource=00 (bubble).
REQ-009 SHALL resolve beq/bne in ID using forwarded da/db: pcsource=01 when taken; jr 10; j/jal 11; else 00.
REQ-010 Register file: 31x32 registers ($1-$31), two combinational read ports (rs, rt), one write port written on rising clock edge when wwreg=1 and wrn!=0; write to $0 ignored.
REQ-011 Same-cycle WB write and ID read of same register SHALL return wdi (write-through bypass).
REQ-012 All outputs other than regfile state SHALL be combinational from inputs and regfile contents; latency zero cycles.

Reset
REQ-013 resetn=0 SHALL asynchronously clear all 31 registers to 0, independent of clock.
REQ-014 During reset, inst from the cleared IF/ID register is 0 (sll $0,$0,0); outputs SHALL follow decode of that: wreg=1, drn=0, shift=1, aluc=0011, wpcir=1, pcsource=00.
REQ-015 Write asserted in same cycle as reset release SHALL not occur; first write occurs at the first rising edge with resetn=1.

Structure
REQ-016 Opcode/funct constants, aluc codes and pcsource codes SHALL live in shared package pipe_pkg.
REQ-017 Register file SHALL be sub-module pipe_regfile; decode, forwarding and hazard logic stay in pipe_id_stage.

Verification
REQ-018 Reset then write $5=0x1234 via WB, next cycle add $6,$5,$0 -> da=0x00001234, drn=6, wreg=1.
REQ-019 ern=3, ewreg=1, em2reg=1, inst=add $4,$3,$2 -> wpcir=0, wreg=0, wmem=0; same with em2reg=0, ealu=0xAA -> wpcir=1, da=0xAA.
REQ-020 ern=mrn=7, both write, ealu=1, malu=2, inst uses $7 -> da=1; ern=0 with ealu=9 for $0 source -> da=0.
REQ-021 beq $1,$2,-1 with $1=$2=5, dpc4=0x100 -> pcsource=01, bpc=0x000000FC; with $2=6 -> pcsource=00.
REQ-022 jal 0x0000010, dpc4=0x80000004 -> pcsource=11, jpc=0x80000040, drn=31, jal=1.
REQ-023 resetn pulsed low mid-run after writing $9=0xFFFF -> rs=9 reads 0 immediately, before next clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Opcode/funct encodings, ALU and next-PC select codes, and the control decode for the ID stage.
// Definitions only: no state, no timing.
package pipe_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_SRA   = 6'b000011;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_XOR   = 6'b100110;

   localparam logic [4:0] LINK_REG = 5'd31;

   typedef enum logic [3:0] {
      ALUC_ADD = 4'b0000,
      ALUC_AND = 4'b0001,
      ALUC_XOR = 4'b0010,
      ALUC_SLL = 4'b0011,
      ALUC_SUB = 4'b0100,
      ALUC_OR  = 4'b0101,
      ALUC_LUI = 4'b0110,
      ALUC_SRL = 4'b0111,
      ALUC_SRA = 4'b1111
   } aluc_e;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JR     = 2'b10,
      PC_JUMP   = 2'b11
   } pcsel_e;

   typedef struct packed {
      logic  wreg;
      logic  m2reg;
      logic  wmem;
      logic  jal;
      logic  aluimm;
      logic  shift;
      logic  regrt;   // destination is rt rather than rd
      logic  sext;    // sign-extend imm16
      logic  use_rs;
      logic  use_rt;
      logic  is_beq;
      logic  is_bne;
      logic  is_jr;
      logic  is_j;    // j and jal
      aluc_e aluc;
   } ctrl_t;

   function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] fn);
      ctrl_t c;
      c      = '0;
      c.sext = 1'b1;
      c.aluc = ALUC_ADD;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADD: begin c.wreg = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; c.aluc = ALUC_ADD; end
               FN_SUB: begin c.wreg = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; c.aluc = ALUC_SUB; end
               FN_AND: begin c.wreg = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; c.aluc = ALUC_AND; end
               FN_OR:  begin c.wreg = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; c.aluc = ALUC_OR;  end
               FN_XOR: begin c.wreg = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; c.aluc = ALUC_XOR; end
               FN_SLL: begin c.wreg = 1'b1; c.shift = 1'b1; c.use_rt = 1'b1; c.aluc = ALUC_SLL; end
               FN_SRL: begin c.wreg = 1'b1; c.shift = 1'b1; c.use_rt = 1'b1; c.aluc = ALUC_SRL; end
               FN_SRA: begin c.wreg = 1'b1; c.shift = 1'b1; c.use_rt = 1'b1; c.aluc = ALUC_SRA; end
               FN_JR:  begin c.is_jr = 1'b1; c.use_rs = 1'b1; end
               default: ;
            endcase
         end
         OP_ADDI: begin
            c.wreg = 1'b1; c.aluimm = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.aluc = ALUC_ADD;
         end
         OP_ANDI: begin
            c.wreg = 1'b1; c.aluimm = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.sext = 1'b0;
            c.aluc = ALUC_AND;
         end
         OP_ORI: begin
            c.wreg = 1'b1; c.aluimm = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.sext = 1'b0;
            c.aluc = ALUC_OR;
         end
         OP_XORI: begin
            c.wreg = 1'b1; c.aluimm = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.sext = 1'b0;
            c.aluc = ALUC_XOR;
         end
         OP_LUI: begin
            c.wreg = 1'b1; c.aluimm = 1'b1; c.regrt = 1'b1; c.aluc = ALUC_LUI;
         end
         OP_LW: begin
            c.wreg = 1'b1; c.m2reg = 1'b1; c.aluimm = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1;
            c.aluc = ALUC_ADD;
         end
         OP_SW: begin
            c.wmem = 1'b1; c.aluimm = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1;
            c.aluc = ALUC_ADD;
         end
         OP_BEQ: begin
            c.is_beq = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; c.aluc = ALUC_SUB;
         end
         OP_BNE: begin
            c.is_bne = 1'b1; c.regrt = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; c.aluc = ALUC_SUB;
         end
         OP_J:   c.is_j = 1'b1;
         OP_JAL: begin c.is_j = 1'b1; c.jal = 1'b1; c.wreg = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipe_regfile.sv
// 31x32 register file ($0 hard-wired to zero), two combinational read ports with WB write-through.
// Reads are zero-latency; one write per rising edge, suppressed while reset is asserted.
module pipe_regfile (
   input  logic        clock,
   input  logic        resetn,
   input  logic [4:0]  i_ra,
   input  logic [4:0]  i_rb,
   input  logic        i_we,
   input  logic [4:0]  i_wn,
   input  logic [31:0] i_wd,
   output logic [31:0] o_qa,
   output logic [31:0] o_qb
);

   logic [31:0] r_regs [1:31];
   logic        w_wr_en;
   logic        w_byp_a;
   logic        w_byp_b;

   assign w_wr_en = i_we & resetn & (i_wn != 5'd0);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 1; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[i_wn] <= i_wd;
      end
   end

   // A register written this cycle reads back the incoming value, not the stale one.
   assign w_byp_a = w_wr_en & (i_wn == i_ra);
   assign w_byp_b = w_wr_en & (i_wn == i_rb);

   assign o_qa = (i_ra == 5'd0) ? 32'd0 : (w_byp_a ? i_wd : r_regs[i_ra]);
   assign o_qb = (i_rb == 5'd0) ? 32'd0 : (w_byp_b ? i_wd : r_regs[i_rb]);

endmodule

// File: rtl/pipe_id_stage.sv
// Instruction decode stage: control decode, operand forwarding, load-use stall and branch/jump resolution.
// Combinational outputs (zero latency); wpcir=0 holds PC and IF/ID and inserts a bubble into ID/EX.
module pipe_id_stage
   import pipe_pkg::*;
(
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] dpc4,
   input  logic [31:0] inst,
   input  logic [4:0]  ern,
   input  logic [4:0]  mrn,
   input  logic [4:0]  wrn,
   input  logic        ewreg,
   input  logic        em2reg,
   input  logic        mwreg,
   input  logic        mm2reg,
   input  logic        wwreg,
   input  logic [31:0] ealu,
   input  logic [31:0] malu,
   input  logic [31:0] mmo,
   input  logic [31:0] wdi,
   output logic        wpcir,
   output logic [1:0]  pcsource,
   output logic [31:0] bpc,
   output logic [31:0] jpc,
   output logic [31:0] da,
   output logic [31:0] db,
   output logic [31:0] dimm,
   output logic [4:0]  drn,
   output logic        wreg,
   output logic        m2reg,
   output logic        wmem,
   output logic        jal,
   output logic        aluimm,
   output logic        shift,
   output logic [3:0]  aluc
);

   logic [5:0]  w_op;
   logic [5:0]  w_fn;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [15:0] w_imm;
   ctrl_t       w_ctrl;
   logic [31:0] w_qa;
   logic [31:0] w_qb;
   logic        w_stall;
   logic        w_taken;
   logic [31:0] w_sext_imm;

   assign w_op  = inst[31:26];
   assign w_rs  = inst[25:21];
   assign w_rt  = inst[20:16];
   assign w_rd  = inst[15:11];
   assign w_imm = inst[15:0];
   assign w_fn  = inst[5:0];

   assign w_ctrl = decode_ctrl(w_op, w_fn);

   pipe_regfile u_regfile (
      .clock  (clock),
      .resetn (resetn),
      .i_ra   (w_rs),
      .i_rb   (w_rt),
      .i_we   (wwreg),
      .i_wn   (wrn),
      .i_wd   (wdi),
      .o_qa   (w_qa),
      .o_qb   (w_qb)
   );

   // WB forwarding is handled inside the register file by its write-through path.
   function automatic logic [31:0] fwd_sel(
      input logic [4:0]  src,
      input logic [31:0] rf_q,
      input logic [4:0]  e_rn,
      input logic        e_wr,
      input logic        e_ld,
      input logic [31:0] e_alu,
      input logic [4:0]  m_rn,
      input logic        m_wr,
      input logic        m_ld,
      input logic [31:0] m_alu,
      input logic [31:0] m_mo
   );
      logic [31:0] v;
      if (src == 5'd0)                          v = 32'd0;
      else if (e_wr && !e_ld && e_rn == src)    v = e_alu;
      else if (m_wr && !m_ld && m_rn == src)    v = m_alu;
      else if (m_wr &&  m_ld && m_rn == src)    v = m_mo;
      else                                      v = rf_q;
      return v;
   endfunction

   assign da = fwd_sel(w_rs, w_qa, ern, ewreg, em2reg, ealu, mrn, mwreg, mm2reg, malu, mmo);
   assign db = fwd_sel(w_rt, w_qb, ern, ewreg, em2reg, ealu, mrn, mwreg, mm2reg, malu, mmo);

   assign w_stall = ewreg & em2reg & (ern != 5'd0) &
                    ((w_ctrl.use_rs & (ern == w_rs)) | (w_ctrl.use_rt & (ern == w_rt)));
   assign wpcir   = ~w_stall;

   assign w_taken = (w_ctrl.is_beq & (da == db)) | (w_ctrl.is_bne & (da != db));

   always_comb begin
      pcsource = PC_SEQ;
      if (!w_stall) begin
         if (w_taken)             pcsource = PC_BRANCH;
         else if (w_ctrl.is_jr)   pcsource = PC_JR;
         else if (w_ctrl.is_j)    pcsource = PC_JUMP;
      end
   end

   assign w_sext_imm = {{16{w_imm[15]}}, w_imm};
   assign dimm       = w_ctrl.sext ? w_sext_imm : {16'd0, w_imm};
   assign bpc        = dpc4 + {w_sext_imm[29:0], 2'b00};
   assign jpc        = {dpc4[31:28], inst[25:0], 2'b00};

   assign drn    = w_ctrl.jal ? LINK_REG : (w_ctrl.regrt ? w_rt : w_rd);
   assign wreg   = w_ctrl.wreg & ~w_stall;
   assign wmem   = w_ctrl.wmem & ~w_stall;
   assign jal    = w_ctrl.jal  & ~w_stall;
   assign m2reg  = w_ctrl.m2reg;
   assign aluimm = w_ctrl.aluimm;
   assign shift  = w_ctrl.shift;
   assign aluc   = w_ctrl.aluc;

endmodule
